// File: rtl/axi_lite_pkg.sv
// ============================================================================
// Module   : axi_lite_pkg
// Brief    : Shared response codes, FSM state types and address decode helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi_lite_pkg;

    localparam int MAX_SLAVES = 16;
    localparam int MAX_ADDR_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} wr_state_t;

    typedef logic [MAX_ADDR_W-1:0] addr_max_t;
    typedef addr_max_t addr_tbl_t [MAX_SLAVES];

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } dec_t;

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    function automatic dec_t addr_decode(input addr_max_t addr,
                                         input addr_tbl_t base,
                                         input addr_tbl_t mask,
                                         input int        num);
        dec_t res;
        res = '0;
        for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
            if ((i < num) && ((addr & mask[i]) == base[i])) begin
                res.hit = 1'b1;
                res.idx = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_p_if.sv
// ============================================================================
// Module   : axi_lite_p_if
// Brief    : Parametrised AXI-Lite interface (address/data width, byte strobes).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axi_lite_p_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

`default_nettype wire

// File: rtl/axi_lite_addr_dec.sv
// ============================================================================
// Module   : axi_lite_addr_dec
// Brief    : Combinational base/mask address decoder, lowest matching index wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_lite_addr_dec
    import axi_lite_pkg::*;
#(
    parameter int                NUM_SLAVES = 2,
    parameter int                ADDR_W     = 32,
    parameter int                IDX_W      = 1,
    parameter logic [ADDR_W-1:0] SLV_BASE [NUM_SLAVES] = '{32'h8000_0000, 32'hA000_0000},
    parameter logic [ADDR_W-1:0] SLV_MASK [NUM_SLAVES] = '{32'hF800_0000, 32'hFFFF_F000}
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    addr_tbl_t w_base;
    addr_tbl_t w_mask;
    dec_t      w_dec;

    always_comb begin
        // Unused table slots can never match: all-ones base against a zero mask.
        for (int i = 0; i < MAX_SLAVES; i++) begin
            w_base[i] = '1;
            w_mask[i] = '0;
        end
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_base[i] = MAX_ADDR_W'(SLV_BASE[i]);
            w_mask[i] = MAX_ADDR_W'(SLV_MASK[i]);
        end
        w_dec = addr_decode(MAX_ADDR_W'(addr), w_base, w_mask, NUM_SLAVES);
    end

    assign hit = w_dec.hit;
    assign idx = w_dec.idx[IDX_W-1:0];

endmodule

`default_nettype wire

// File: rtl/axi_lite_xbar.sv
// ============================================================================
// Module   : axi_lite_xbar
// Brief    : 1-to-N AXI-Lite crossbar, independent read/write paths, DECERR sink.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_lite_xbar
    import axi_lite_pkg::*;
#(
    parameter int                NUM_SLAVES = 2,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] SLV_BASE [NUM_SLAVES] = '{32'h8000_0000, 32'hA000_0000},
    parameter logic [ADDR_W-1:0] SLV_MASK [NUM_SLAVES] = '{32'hF800_0000, 32'hFFFF_F000}
) (
    input  logic         clk,
    input  logic         rst_n,
    axi_lite_p_if.slave  up,
    axi_lite_p_if.master dn [NUM_SLAVES]
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if ((NUM_SLAVES < 1) || (NUM_SLAVES > MAX_SLAVES) || ((DATA_W != 32) && (DATA_W != 64))) begin : g_bad_cfg
        $fatal(1, "axi_lite_xbar: unsupported NUM_SLAVES=%0d / DATA_W=%0d", NUM_SLAVES, DATA_W);
    end

    rd_state_t         r_rd_state;
    logic [ADDR_W-1:0] r_araddr;
    logic [IDX_W-1:0]  r_rd_sel;

    wr_state_t         r_wr_state;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [IDX_W-1:0]  r_wr_sel;
    logic              r_aw_done;
    logic              r_w_done;

    logic              w_rd_hit;
    logic              w_wr_hit;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_wr_idx;

    logic [NUM_SLAVES-1:0] w_dn_arready;
    logic [NUM_SLAVES-1:0] w_dn_rvalid;
    logic [NUM_SLAVES-1:0] w_dn_awready;
    logic [NUM_SLAVES-1:0] w_dn_wready;
    logic [NUM_SLAVES-1:0] w_dn_bvalid;
    logic [DATA_W-1:0]     w_dn_rdata [NUM_SLAVES];
    logic [1:0]            w_dn_rresp [NUM_SLAVES];
    logic [1:0]            w_dn_bresp [NUM_SLAVES];

    logic w_wr_go;
    logic w_aw_fire;
    logic w_w_fire;

    axi_lite_addr_dec #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_rd_dec (
        .addr (up.araddr),
        .hit  (w_rd_hit),
        .idx  (w_rd_idx)
    );

    axi_lite_addr_dec #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_wr_dec (
        .addr (up.awaddr),
        .hit  (w_wr_hit),
        .idx  (w_wr_idx)
    );

    // Interface arrays only take constant indices, so each port is flattened here.
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dn
        assign dn[gi].arvalid = (r_rd_state == R_ADDR) && (r_rd_sel == IDX_W'(gi));
        assign dn[gi].araddr  = r_araddr;
        assign dn[gi].rready  = (r_rd_state == R_DATA) && (r_rd_sel == IDX_W'(gi)) && up.rready;
        assign dn[gi].awvalid = (r_wr_state == W_FWD) && (r_wr_sel == IDX_W'(gi)) && !r_aw_done;
        assign dn[gi].awaddr  = r_awaddr;
        assign dn[gi].wvalid  = (r_wr_state == W_FWD) && (r_wr_sel == IDX_W'(gi)) && !r_w_done;
        assign dn[gi].wdata   = r_wdata;
        assign dn[gi].wstrb   = r_wstrb;
        assign dn[gi].bready  = (r_wr_state == W_RESP) && (r_wr_sel == IDX_W'(gi)) && up.bready;

        assign w_dn_arready[gi] = dn[gi].arready;
        assign w_dn_rvalid[gi]  = dn[gi].rvalid;
        assign w_dn_rdata[gi]   = dn[gi].rdata;
        assign w_dn_rresp[gi]   = dn[gi].rresp;
        assign w_dn_awready[gi] = dn[gi].awready;
        assign w_dn_wready[gi]  = dn[gi].wready;
        assign w_dn_bvalid[gi]  = dn[gi].bvalid;
        assign w_dn_bresp[gi]   = dn[gi].bresp;
    end

    assign up.arready = rst_n && (r_rd_state == R_IDLE);
    assign up.rvalid  = (r_rd_state == R_DATA) ? w_dn_rvalid[r_rd_sel] : (r_rd_state == R_ERR);
    assign up.rdata   = (r_rd_state == R_DATA) ? w_dn_rdata[r_rd_sel] : '0;
    assign up.rresp   = (r_rd_state == R_DATA) ? w_dn_rresp[r_rd_sel] :
                        (r_rd_state == R_ERR)  ? RESP_DECERR : RESP_OKAY;

    // AW and W are only taken together so the forward stage always has both.
    assign w_wr_go    = rst_n && (r_wr_state == W_IDLE) && up.awvalid && up.wvalid;
    assign up.awready = w_wr_go;
    assign up.wready  = w_wr_go;
    assign up.bvalid  = (r_wr_state == W_RESP) ? w_dn_bvalid[r_wr_sel] : (r_wr_state == W_ERR);
    assign up.bresp   = (r_wr_state == W_RESP) ? w_dn_bresp[r_wr_sel] :
                        (r_wr_state == W_ERR)  ? RESP_DECERR : RESP_OKAY;

    assign w_aw_fire = (r_wr_state == W_FWD) && !r_aw_done && w_dn_awready[r_wr_sel];
    assign w_w_fire  = (r_wr_state == W_FWD) && !r_w_done  && w_dn_wready[r_wr_sel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_state <= R_IDLE;
            r_araddr   <= '0;
            r_rd_sel   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (up.arvalid) begin
                        r_araddr   <= up.araddr;
                        r_rd_sel   <= w_rd_idx;
                        r_rd_state <= w_rd_hit ? R_ADDR : R_ERR;
                    end
                end
                R_ADDR: if (w_dn_arready[r_rd_sel]) r_rd_state <= R_DATA;
                R_DATA: if (w_dn_rvalid[r_rd_sel] && up.rready) r_rd_state <= R_IDLE;
                R_ERR:  if (up.rready) r_rd_state <= R_IDLE;
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wr_sel   <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_wr_go) begin
                        r_awaddr   <= up.awaddr;
                        r_wdata    <= up.wdata;
                        r_wstrb    <= up.wstrb;
                        r_wr_sel   <= w_wr_idx;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_wr_state <= w_wr_hit ? W_FWD : W_ERR;
                    end
                end
                W_FWD: begin
                    r_aw_done <= r_aw_done | w_aw_fire;
                    r_w_done  <= r_w_done  | w_w_fire;
                    if ((r_aw_done | w_aw_fire) && (r_w_done | w_w_fire)) r_wr_state <= W_RESP;
                end
                W_RESP: if (w_dn_bvalid[r_wr_sel] && up.bready) r_wr_state <= W_IDLE;
                W_ERR:  if (up.bready) r_wr_state <= W_IDLE;
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_xbar.sv
// ============================================================================
// Module   : tb_axi_lite_xbar
// Brief    : Directed self-checking bench for the AXI-Lite crossbar.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_xbar;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   dn1_act;
    int   aw1_hs;
    int   w1_hs;
    int   ar_seen;
    int   aw_seen;
    int   s0;
    int   s1;

    axi_lite_p_if #(.ADDR_W(32), .DATA_W(32)) up_if ();
    axi_lite_p_if #(.ADDR_W(32), .DATA_W(32)) dn_if [2] ();
    axi_lite_p_if #(.ADDR_W(32), .DATA_W(32)) up2 ();
    axi_lite_p_if #(.ADDR_W(32), .DATA_W(32)) dn2 [2] ();

    axi_lite_xbar #(
        .NUM_SLAVES (2),
        .ADDR_W     (32),
        .DATA_W     (32),
        .SLV_BASE   ('{32'h8000_0000, 32'hA000_0000}),
        .SLV_MASK   ('{32'hF800_0000, 32'hFFFF_F000})
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (up_if),
        .dn    (dn_if)
    );

    // Overlapping map: address 0x8000_0000 hits both slaves.
    axi_lite_xbar #(
        .NUM_SLAVES (2),
        .ADDR_W     (32),
        .DATA_W     (32),
        .SLV_BASE   ('{32'h8000_0000, 32'h8000_0000}),
        .SLV_MASK   ('{32'hF800_0000, 32'hFFFF_F000})
    ) u_ovl (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (up2),
        .dn    (dn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dn_if[1].arvalid || dn_if[1].rready || dn_if[1].awvalid || dn_if[1].wvalid || dn_if[1].bready)
            dn1_act++;
        if (dn_if[1].awvalid && dn_if[1].awready) aw1_hs++;
        if (dn_if[1].wvalid && dn_if[1].wready) w1_hs++;
        if (dn_if[0].arvalid || dn_if[1].arvalid) ar_seen++;
        if (dn_if[0].awvalid || dn_if[1].awvalid || dn_if[0].wvalid || dn_if[1].wvalid) aw_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; dn1_act = 0; aw1_hs = 0; w1_hs = 0; ar_seen = 0; aw_seen = 0;
        rst_n = 1'b0;
        up_if.arvalid = 0; up_if.araddr = '0; up_if.rready = 0;
        up_if.awvalid = 0; up_if.awaddr = '0; up_if.wvalid = 0; up_if.wdata = '0; up_if.wstrb = '0;
        up_if.bready = 0;
        up2.arvalid = 0; up2.araddr = '0; up2.rready = 0;
        up2.awvalid = 0; up2.awaddr = '0; up2.wvalid = 0; up2.wdata = '0; up2.wstrb = '0; up2.bready = 0;
        dn_if[0].arready = 0; dn_if[0].rvalid = 0; dn_if[0].rdata = '0; dn_if[0].rresp = '0;
        dn_if[0].awready = 0; dn_if[0].wready = 0; dn_if[0].bvalid = 0; dn_if[0].bresp = '0;
        dn_if[1].arready = 0; dn_if[1].rvalid = 0; dn_if[1].rdata = '0; dn_if[1].rresp = '0;
        dn_if[1].awready = 0; dn_if[1].wready = 0; dn_if[1].bvalid = 0; dn_if[1].bresp = '0;
        dn2[0].arready = 0; dn2[0].rvalid = 0; dn2[0].rdata = '0; dn2[0].rresp = '0;
        dn2[0].awready = 0; dn2[0].wready = 0; dn2[0].bvalid = 0; dn2[0].bresp = '0;
        dn2[1].arready = 0; dn2[1].rvalid = 0; dn2[1].rdata = '0; dn2[1].rresp = '0;
        dn2[1].awready = 0; dn2[1].wready = 0; dn2[1].bvalid = 0; dn2[1].bresp = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_arready", up_if.arready, 0);
        chk("rst_awready", up_if.awready, 0);
        chk("rst_rvalid", up_if.rvalid, 0);
        chk("rst_bvalid", up_if.bvalid, 0);
        chk("rst_rdata", up_if.rdata, 0);
        chk("rst_rresp", up_if.rresp, 0);
        chk("rst_bresp", up_if.bresp, 0);
        chk("rst_dn0_arvalid", dn_if[0].arvalid, 0);
        rst_n = 1'b1; #1;
        chk("post_rst_arready", up_if.arready, 1);

        // Read slave0 with 3-cycle data latency
        s0 = dn1_act;
        up_if.araddr = 32'h8000_0010; up_if.arvalid = 1; up_if.rready = 1; #1;
        chk("t1_up_arready", up_if.arready, 1);
        tick(); up_if.arvalid = 0;
        chk("t1_dn0_arvalid", dn_if[0].arvalid, 1);
        chk("t1_dn0_araddr", dn_if[0].araddr, 32'h8000_0010);
        chk("t1_dn1_arvalid", dn_if[1].arvalid, 0);
        chk("t1_up_arready_busy", up_if.arready, 0);
        dn_if[0].arready = 1; tick(); dn_if[0].arready = 0;
        chk("t1_dn0_arvalid_drop", dn_if[0].arvalid, 0);
        chk("t1_dn0_rready", dn_if[0].rready, 1);
        tick(); tick();
        chk("t1_up_rvalid_wait", up_if.rvalid, 0);
        dn_if[0].rvalid = 1; dn_if[0].rdata = 32'hDEAD_BEEF; dn_if[0].rresp = 2'b00; #1;
        chk("t1_up_rvalid", up_if.rvalid, 1);
        chk("t1_up_rdata", up_if.rdata, 32'hDEAD_BEEF);
        chk("t1_up_rresp", up_if.rresp, 0);
        tick(); dn_if[0].rvalid = 0; dn_if[0].rdata = '0; #1;
        chk("t1_up_rvalid_done", up_if.rvalid, 0);
        chk("t1_arready_again", up_if.arready, 1);
        chk("t1_dn1_idle", dn1_act - s0, 0);

        // Write slave1, awready two cycles ahead of wready
        s0 = aw1_hs; s1 = w1_hs;
        up_if.awaddr = 32'hA000_03F8; up_if.wdata = 32'h41; up_if.wstrb = 4'b0001;
        up_if.awvalid = 1; up_if.wvalid = 1; up_if.bready = 0; #1;
        chk("t2_up_awready", up_if.awready, 1);
        chk("t2_up_wready", up_if.wready, 1);
        tick(); up_if.awvalid = 0; up_if.wvalid = 0;
        chk("t2_dn1_awvalid", dn_if[1].awvalid, 1);
        chk("t2_dn1_wvalid", dn_if[1].wvalid, 1);
        chk("t2_dn1_awaddr", dn_if[1].awaddr, 32'hA000_03F8);
        chk("t2_dn1_wdata", dn_if[1].wdata, 32'h41);
        chk("t2_dn1_wstrb", dn_if[1].wstrb, 4'b0001);
        chk("t2_dn0_awvalid", dn_if[0].awvalid, 0);
        dn_if[1].awready = 1; tick(); dn_if[1].awready = 0;
        chk("t2_dn1_awvalid_drop", dn_if[1].awvalid, 0);
        chk("t2_dn1_wvalid_hold", dn_if[1].wvalid, 1);
        tick();
        chk("t2_dn1_wvalid_hold2", dn_if[1].wvalid, 1);
        dn_if[1].wready = 1; tick(); dn_if[1].wready = 0;
        chk("t2_dn1_wvalid_drop", dn_if[1].wvalid, 0);
        chk("t2_up_bvalid_wait", up_if.bvalid, 0);
        dn_if[1].bvalid = 1; dn_if[1].bresp = 2'b00; up_if.bready = 1; #1;
        chk("t2_up_bvalid", up_if.bvalid, 1);
        chk("t2_up_bresp", up_if.bresp, 0);
        chk("t2_dn1_bready", dn_if[1].bready, 1);
        tick(); dn_if[1].bvalid = 0; up_if.bready = 0; #1;
        chk("t2_up_bvalid_done", up_if.bvalid, 0);
        chk("t2_aw_handshakes", aw1_hs - s0, 1);
        chk("t2_w_handshakes", w1_hs - s1, 1);

        // Unmapped read and write complete locally with DECERR
        s0 = ar_seen;
        up_if.rready = 0; up_if.araddr = 32'h0000_1000; up_if.arvalid = 1;
        tick(); up_if.arvalid = 0;
        chk("t3_err_rvalid", up_if.rvalid, 1);
        chk("t3_err_rresp", up_if.rresp, 2'b11);
        chk("t3_err_rdata", up_if.rdata, 0);
        tick();
        chk("t3_err_rvalid_hold", up_if.rvalid, 1);
        up_if.rready = 1; tick(); up_if.rready = 0;
        chk("t3_err_rvalid_done", up_if.rvalid, 0);
        chk("t3_no_dn_arvalid", ar_seen - s0, 0);
        s0 = aw_seen;
        up_if.awaddr = 32'h0000_1000; up_if.wdata = 32'h99; up_if.wstrb = 4'hF;
        up_if.awvalid = 1; up_if.wvalid = 1;
        tick(); up_if.awvalid = 0; up_if.wvalid = 0;
        chk("t3_err_bvalid", up_if.bvalid, 1);
        chk("t3_err_bresp", up_if.bresp, 2'b11);
        up_if.bready = 1; tick(); up_if.bready = 0;
        chk("t3_err_bvalid_done", up_if.bvalid, 0);
        chk("t3_no_dn_aw_w", aw_seen - s0, 0);

        // Concurrent read slave0 / write slave1 with R stalled
        up_if.araddr = 32'h8000_0100; up_if.arvalid = 1; up_if.rready = 0;
        up_if.awaddr = 32'hA000_0004; up_if.wdata = 32'h1234_5678; up_if.wstrb = 4'hF;
        up_if.awvalid = 1; up_if.wvalid = 1; up_if.bready = 1;
        tick(); up_if.arvalid = 0; up_if.awvalid = 0; up_if.wvalid = 0;
        chk("t4_dn0_arvalid", dn_if[0].arvalid, 1);
        chk("t4_dn1_awvalid", dn_if[1].awvalid, 1);
        chk("t4_dn1_wdata", dn_if[1].wdata, 32'h1234_5678);
        dn_if[0].arready = 1; dn_if[1].awready = 1; dn_if[1].wready = 1;
        tick(); dn_if[0].arready = 0; dn_if[1].awready = 0; dn_if[1].wready = 0;
        dn_if[0].rvalid = 1; dn_if[0].rdata = 32'hCAFE_F00D; dn_if[0].rresp = 2'b00;
        dn_if[1].bvalid = 1; dn_if[1].bresp = 2'b00; #1;
        chk("t4_up_bvalid", up_if.bvalid, 1);
        chk("t4_dn0_rready_stall", dn_if[0].rready, 0);
        tick(); dn_if[1].bvalid = 0; #1;
        chk("t4_up_bvalid_done", up_if.bvalid, 0);
        for (int k = 0; k < 3; k++) begin
            chk("t4_stall_rvalid", up_if.rvalid, 1);
            chk("t4_stall_rdata", up_if.rdata, 32'hCAFE_F00D);
            tick();
        end
        up_if.rready = 1; tick(); dn_if[0].rvalid = 0; #1;
        chk("t4_up_rvalid_done", up_if.rvalid, 0);
        chk("t4_arready_again", up_if.arready, 1);

        // Overlapping map: lowest index wins
        up2.araddr = 32'h8000_0000; up2.arvalid = 1; up2.rready = 1;
        tick(); up2.arvalid = 0;
        chk("t5_dn0_arvalid", dn2[0].arvalid, 1);
        chk("t5_dn1_arvalid", dn2[1].arvalid, 0);
        dn2[0].arready = 1; tick(); dn2[0].arready = 0;
        dn2[0].rvalid = 1; dn2[0].rdata = 32'h0000_0005; #1;
        chk("t5_up_rdata", up2.rdata, 32'h0000_0005);
        tick(); dn2[0].rvalid = 0;

        // Reset mid-transaction: read in R_DATA, write in W_FWD
        up_if.araddr = 32'h8000_0020; up_if.arvalid = 1; up_if.rready = 1;
        up_if.awaddr = 32'hA000_0008; up_if.wdata = 32'h77; up_if.wstrb = 4'hF;
        up_if.awvalid = 1; up_if.wvalid = 1; up_if.bready = 1;
        tick(); up_if.arvalid = 0; up_if.awvalid = 0; up_if.wvalid = 0;
        dn_if[0].arready = 1; tick(); dn_if[0].arready = 0;
        chk("t6_pre_dn0_rready", dn_if[0].rready, 1);
        chk("t6_pre_dn1_awvalid", dn_if[1].awvalid, 1);
        rst_n = 0; tick();
        chk("t6_rst_dn0_arvalid", dn_if[0].arvalid, 0);
        chk("t6_rst_dn0_rready", dn_if[0].rready, 0);
        chk("t6_rst_dn1_awvalid", dn_if[1].awvalid, 0);
        chk("t6_rst_dn1_wvalid", dn_if[1].wvalid, 0);
        chk("t6_rst_up_rvalid", up_if.rvalid, 0);
        chk("t6_rst_up_bvalid", up_if.bvalid, 0);
        rst_n = 1; #1;
        chk("t6_idle_arready", up_if.arready, 1);
        up_if.araddr = 32'h8000_0030; up_if.arvalid = 1;
        tick(); up_if.arvalid = 0;
        chk("t6_new_dn0_araddr", dn_if[0].araddr, 32'h8000_0030);
        dn_if[0].arready = 1; tick(); dn_if[0].arready = 0;
        dn_if[0].rvalid = 1; dn_if[0].rdata = 32'h600D_0001; #1;
        chk("t6_new_rdata", up_if.rdata, 32'h600D_0001);
        tick(); dn_if[0].rvalid = 0; #1;
        chk("t6_new_rvalid_done", up_if.rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
